// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter for the shared data-memory port.
// Port 0 is instruction fetch and port 1 is load/store. Each granted command
// is registered onto the memory bus. A watchdog aborts accesses that the
// memory never acknowledges.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req0,
  input  logic          i_req1,
  input  logic          i_we0,
  input  logic          i_we1,
  input  logic [AW-1:0] i_addr0,
  input  logic [AW-1:0] i_addr1,
  input  logic [DW-1:0] i_wdata0,
  input  logic [DW-1:0] i_wdata1,
  output logic          o_done0,
  output logic          o_done1,
  output logic          o_err0,
  output logic          o_err1,
  output logic [DW-1:0] o_rdata,
  output logic          o_busy,
  output logic          o_mreq,
  output logic          o_mwe,
  output logic [AW-1:0] o_maddr,
  output logic [DW-1:0] o_mwdata,
  input  logic          i_mack,
  input  logic [DW-1:0] i_mrdata
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_n;
  logic       last;      // last-served port; the other port wins a tie
  logic       owner;     // port that owns the access in flight
  logic [7:0] cnt;       // BUSY cycles elapsed for the watchdog
  logic       elig0, elig1;
  logic       grant, gnt_port;
  logic       ack_hit, tmo_hit;

  // Next-state logic: arbitration in IDLE, ack/watchdog resolution in BUSY.
  always_comb begin
    state_n  = state;
    grant    = 1'b0;
    gnt_port = 1'b0;
    ack_hit  = 1'b0;
    tmo_hit  = 1'b0;
    // A port whose done is showing cannot be re-granted, so it may drop req
    // one cycle after done without starting a second access.
    elig0    = i_req0 & ~o_done0;
    elig1    = i_req1 & ~o_done1;
    case (state)
      IDLE: begin
        if (elig0 | elig1) begin
          grant    = 1'b1;
          gnt_port = (elig0 & elig1) ? ~last : elig1;
          state_n  = BUSY;
        end
      end
      BUSY: begin
        // An ack in the same cycle as the timeout completes normally.
        if (i_mack) begin
          ack_hit = 1'b1;
          state_n = IDLE;
        end else if ((TIMEOUT != 0) && (cnt == TMO_LAST)) begin
          tmo_hit = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  assign o_busy = (state == BUSY);

  // Registered memory command, watchdog counter and completion outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last     <= 1'b1;
      owner    <= 1'b0;
      cnt      <= '0;
      o_mreq   <= 1'b0;
      o_mwe    <= 1'b0;
      o_maddr  <= '0;
      o_mwdata <= '0;
      o_rdata  <= '0;
      o_done0  <= 1'b0;
      o_done1  <= 1'b0;
      o_err0   <= 1'b0;
      o_err1   <= 1'b0;
    end else begin
      o_done0 <= 1'b0;
      o_done1 <= 1'b0;
      o_err0  <= 1'b0;
      o_err1  <= 1'b0;
      if (grant) begin
        o_maddr  <= gnt_port ? i_addr1  : i_addr0;
        o_mwdata <= gnt_port ? i_wdata1 : i_wdata0;
        o_mwe    <= gnt_port ? i_we1    : i_we0;
        o_mreq   <= 1'b1;
        owner    <= gnt_port;
        last     <= gnt_port;
        cnt      <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt + 8'd1;
        if (ack_hit | tmo_hit) begin
          o_mreq  <= 1'b0;
          o_done0 <= ~owner;
          o_done1 <= owner;
          o_err0  <= tmo_hit & ~owner;
          o_err1  <= tmo_hit & owner;
          if (tmo_hit)     o_rdata <= '0;
          else if (!o_mwe) o_rdata <= i_mrdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a table of per-cycle input/expected
// records plus hand-written reset and tie sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req0, i_req1, i_we0, i_we1, i_mack;
  logic [31:0] i_addr0, i_addr1, i_wdata0, i_wdata1, i_mrdata;
  logic        o_done0, o_done1, o_err0, o_err1, o_busy, o_mreq, o_mwe;
  logic [31:0] o_rdata, o_maddr, o_mwdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) u_dut (
    .clk(clk), .rst(rst),
    .i_req0(i_req0), .i_req1(i_req1), .i_we0(i_we0), .i_we1(i_we1),
    .i_addr0(i_addr0), .i_addr1(i_addr1), .i_wdata0(i_wdata0), .i_wdata1(i_wdata1),
    .o_done0(o_done0), .o_done1(o_done1), .o_err0(o_err0), .o_err1(o_err1),
    .o_rdata(o_rdata), .o_busy(o_busy), .o_mreq(o_mreq), .o_mwe(o_mwe),
    .o_maddr(o_maddr), .o_mwdata(o_mwdata), .i_mack(i_mack), .i_mrdata(i_mrdata)
  );

  typedef struct {
    logic        r0, r1, w0, w1;
    logic [31:0] a0, a1, d0, d1;
    logic        ack;
    logic [31:0] mrd;
    logic        e_mreq, e_mwe;
    logic [31:0] e_maddr, e_mwdata;
    logic        e_busy, e_dn0, e_dn1, e_er0, e_er1;
    logic [31:0] e_rd;
  } vec_t;

  localparam int NV = 32;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    i_req0 = 0; i_req1 = 0; i_we0 = 0; i_we1 = 0;
    i_addr0 = '0; i_addr1 = '0; i_wdata0 = '0; i_wdata1 = '0;
    i_mack = 0; i_mrdata = '0;
  endtask

  initial begin
    // single fetch, ack in first BUSY cycle; req0 held through the done cycle
    tbl[0]  = '{1,0,0,0, 32'h100,0,0,0, 0,0,                  1,0,32'h100,0, 1,0,0,0,0, 0};
    tbl[1]  = '{1,0,0,0, 32'h100,0,0,0, 1,32'hDEADBEEF,       0,0,0,0, 0,1,0,0,0, 32'hDEADBEEF};
    tbl[2]  = '{1,0,0,0, 32'h100,0,0,0, 0,0,                  0,0,0,0, 0,0,0,0,0, 32'hDEADBEEF};
    tbl[3]  = '{0,0,0,0, 0,0,0,0, 0,0,                        0,0,0,0, 0,0,0,0,0, 32'hDEADBEEF};
    // tie with last=0: port 1 first, then alternating; ack in IDLE ignored (8)
    tbl[4]  = '{1,1,0,0, 32'h200,32'h300,0,0, 0,0,            1,0,32'h300,0, 1,0,0,0,0, 32'hDEADBEEF};
    tbl[5]  = '{1,1,0,0, 32'h200,32'h300,0,0, 1,32'h11111111, 0,0,0,0, 0,0,1,0,0, 32'h11111111};
    tbl[6]  = '{1,1,0,0, 32'h200,32'h300,0,0, 0,0,            1,0,32'h200,0, 1,0,0,0,0, 32'h11111111};
    tbl[7]  = '{1,1,0,0, 32'h200,32'h300,0,0, 1,32'h22222222, 0,0,0,0, 0,1,0,0,0, 32'h22222222};
    tbl[8]  = '{1,1,0,0, 32'h200,32'h300,0,0, 1,32'h55555555, 1,0,32'h300,0, 1,0,0,0,0, 32'h22222222};
    tbl[9]  = '{1,1,0,0, 32'h200,32'h300,0,0, 1,32'h33333333, 0,0,0,0, 0,0,1,0,0, 32'h33333333};
    tbl[10] = '{1,0,0,0, 32'h200,32'h300,0,0, 0,0,            1,0,32'h200,0, 1,0,0,0,0, 32'h33333333};
    tbl[11] = '{1,0,0,0, 32'h200,32'h300,0,0, 1,32'h44444444, 0,0,0,0, 0,1,0,0,0, 32'h44444444};
    tbl[12] = '{0,0,0,0, 0,0,0,0, 0,0,                        0,0,0,0, 0,0,0,0,0, 32'h44444444};
    // write on port 1, 3 wait cycles, inputs change while BUSY; ack lands on TIMEOUT-1
    tbl[13] = '{0,1,0,1, 0,32'h20,0,32'h12345678, 0,0,        1,1,32'h20,32'h12345678, 1,0,0,0,0, 32'h44444444};
    tbl[14] = '{0,1,0,1, 0,32'h999,0,32'hAAAAAAAA, 0,0,       1,1,32'h20,32'h12345678, 1,0,0,0,0, 32'h44444444};
    tbl[15] = '{0,1,0,0, 0,32'h999,0,32'hAAAAAAAA, 0,0,       1,1,32'h20,32'h12345678, 1,0,0,0,0, 32'h44444444};
    tbl[16] = '{0,1,0,1, 0,32'h777,0,32'hBBBBBBBB, 0,0,       1,1,32'h20,32'h12345678, 1,0,0,0,0, 32'h44444444};
    tbl[17] = '{0,1,0,1, 0,32'h999,0,32'hAAAAAAAA, 1,32'hBADBAD00, 0,0,0,0, 0,0,1,0,0, 32'h44444444};
    tbl[18] = '{0,0,0,0, 0,0,0,0, 0,0,                        0,0,0,0, 0,0,0,0,0, 32'h44444444};
    // timeout read on port 0: four mreq cycles, then err with rdata cleared
    tbl[19] = '{1,0,0,0, 32'h400,0,0,0, 0,0,                  1,0,32'h400,0, 1,0,0,0,0, 32'h44444444};
    tbl[20] = '{1,0,0,0, 32'h400,0,0,0, 0,0,                  1,0,32'h400,0, 1,0,0,0,0, 32'h44444444};
    tbl[21] = '{1,0,0,0, 32'h400,0,0,0, 0,0,                  1,0,32'h400,0, 1,0,0,0,0, 32'h44444444};
    tbl[22] = '{1,0,0,0, 32'h400,0,0,0, 0,0,                  1,0,32'h400,0, 1,0,0,0,0, 32'h44444444};
    tbl[23] = '{1,0,0,0, 32'h400,0,0,0, 0,0,                  0,0,0,0, 0,1,0,1,0, 32'h0};
    tbl[24] = '{1,0,0,0, 32'h400,0,0,0, 0,0,                  0,0,0,0, 0,0,0,0,0, 32'h0};
    tbl[25] = '{0,0,0,0, 0,0,0,0, 0,0,                        0,0,0,0, 0,0,0,0,0, 32'h0};
    // read collision: ack exactly on TIMEOUT-1
    tbl[26] = '{0,1,0,0, 0,32'h500,0,0, 0,0,                  1,0,32'h500,0, 1,0,0,0,0, 32'h0};
    tbl[27] = '{0,1,0,0, 0,32'h500,0,0, 0,0,                  1,0,32'h500,0, 1,0,0,0,0, 32'h0};
    tbl[28] = '{0,1,0,0, 0,32'h500,0,0, 0,0,                  1,0,32'h500,0, 1,0,0,0,0, 32'h0};
    tbl[29] = '{0,1,0,0, 0,32'h500,0,0, 0,0,                  1,0,32'h500,0, 1,0,0,0,0, 32'h0};
    tbl[30] = '{0,1,0,0, 0,32'h500,0,0, 1,32'hCAFEF00D,       0,0,0,0, 0,0,1,0,0, 32'hCAFEF00D};
    tbl[31] = '{0,0,0,0, 0,0,0,0, 0,0,                        0,0,0,0, 0,0,0,0,0, 32'hCAFEF00D};

    drive_idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state",
          {o_mreq, o_mwe, o_busy, o_done0, o_done1, o_err0, o_err1, o_maddr[8:0], o_mwdata[15:0], o_rdata[31:0]},
          64'h0);
    @(negedge clk) rst = 0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      i_req0 = tbl[i].r0;  i_req1 = tbl[i].r1;
      i_we0 = tbl[i].w0;   i_we1 = tbl[i].w1;
      i_addr0 = tbl[i].a0; i_addr1 = tbl[i].a1;
      i_wdata0 = tbl[i].d0; i_wdata1 = tbl[i].d1;
      i_mack = tbl[i].ack; i_mrdata = tbl[i].mrd;
      @(posedge clk);
      #1;
      checks++;
      if (o_mreq !== tbl[i].e_mreq || o_busy !== tbl[i].e_busy ||
          o_done0 !== tbl[i].e_dn0 || o_done1 !== tbl[i].e_dn1 ||
          o_err0 !== tbl[i].e_er0 || o_err1 !== tbl[i].e_er1 || o_rdata !== tbl[i].e_rd ||
          (tbl[i].e_mreq && (o_mwe !== tbl[i].e_mwe || o_maddr !== tbl[i].e_maddr ||
                             o_mwdata !== tbl[i].e_mwdata))) begin
        errors++;
        $display("FAIL vec%0d actual mreq=%b mwe=%b maddr=%h mwdata=%h busy=%b dn=%b%b er=%b%b rd=%h required mreq=%b mwe=%b maddr=%h mwdata=%h busy=%b dn=%b%b er=%b%b rd=%h",
                 i, o_mreq, o_mwe, o_maddr, o_mwdata, o_busy, o_done0, o_done1, o_err0, o_err1, o_rdata,
                 tbl[i].e_mreq, tbl[i].e_mwe, tbl[i].e_maddr, tbl[i].e_mwdata, tbl[i].e_busy,
                 tbl[i].e_dn0, tbl[i].e_dn1, tbl[i].e_er0, tbl[i].e_er1, tbl[i].e_rd);
      end
    end

    // async reset in the middle of an access (last is 1 here)
    @(negedge clk);
    i_req0 = 1; i_addr0 = 32'h600;
    @(posedge clk);
    #1 check("pre_reset_busy", {62'h0, o_mreq, o_busy}, 64'h3);
    #1 rst = 1;
    #1 check("async_reset_drop", {62'h0, o_mreq, o_busy}, 64'h0);
    i_req0 = 0;
    @(posedge clk);
    @(negedge clk) rst = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1 check("no_done_after_reset", {60'h0, o_done0, o_done1, o_mreq, o_busy}, 64'h0);
    end

    // first tie after reset goes to port 0, then port 1
    @(negedge clk);
    i_req0 = 1; i_req1 = 1; i_addr0 = 32'h700; i_addr1 = 32'h800;
    @(posedge clk);
    #1 check("tie_grant0", {31'h0, o_mreq, o_maddr}, {31'h0, 1'b1, 32'h700});
    @(negedge clk) begin i_mack = 1; i_mrdata = 32'h0F0F0F0F; end
    @(posedge clk);
    #1 check("tie_done0", {o_done0, o_done1, o_err0, o_rdata}, {3'b100, 32'h0F0F0F0F});
    @(negedge clk) i_mack = 0;
    @(posedge clk);
    #1 check("tie_grant1", {31'h0, o_mreq, o_maddr}, {31'h0, 1'b1, 32'h800});
    @(negedge clk) begin i_mack = 1; i_mrdata = 32'h13572468; end
    @(posedge clk);
    #1 check("tie_done1", {o_done0, o_done1, o_err1, o_rdata}, {3'b010, 32'h13572468});
    @(negedge clk) drive_idle();
    @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timed out");
  end

endmodule
